// File: rtl/alu_control_sequencer_if.sv
// Instruction-fetch and datapath bundle between the sequencer
// (master) and the instruction memory / register-file / ALU (slave).
interface alu_control_sequencer_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          instr_req;
  logic [DW-1:0] instr_addr;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [DW-1:0] ALUout;
  logic          eq;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic [AW-1:0] rd;
  logic          en;
  logic [DW-1:0] din;
  logic          ALUSrc;
  logic [DW-1:0] ImmOp;
  logic [2:0]    ALU_ctrl;

  modport master (
    output instr_req,
    output instr_addr,
    input  instr_valid,
    input  instr,
    input  ALUout,
    input  eq,
    output rs1,
    output rs2,
    output rd,
    output en,
    output din,
    output ALUSrc,
    output ImmOp,
    output ALU_ctrl
  );

  modport slave (
    input  instr_req,
    input  instr_addr,
    output instr_valid,
    output instr,
    output ALUout,
    output eq,
    input  rs1,
    input  rs2,
    input  rd,
    input  en,
    input  din,
    input  ALUSrc,
    input  ImmOp,
    input  ALU_ctrl
  );
endinterface

// File: rtl/alu_control_sequencer.sv
// Multi-cycle RV32I sequencer for ADDI/ADD/SUB/BEQ/BNE, one op in flight.
// Define SEQ_PERF_CNT_EN to add the instret retired-instruction counter.
module alu_control_sequencer #(
  parameter int Address_Width = 5,
  parameter int Data_Width    = 32,
  parameter logic [Data_Width-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst_n,
  alu_control_sequencer_if.master bus,
  output logic illegal
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [Data_Width-1:0] instret
`endif
);
  localparam int AW = Address_Width;
  localparam int DW = Data_Width;
  localparam logic [DW-1:0] PC_STEP = DW'(4);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    K_ALU,
    K_BEQ,
    K_BNE
  } kind_t;

  state_t r_state;
  state_t w_state_n;
  kind_t  r_kind;
  kind_t  w_kind_n;

  logic [DW-1:0] r_pc;
  logic [DW-1:0] w_pc_n;
  logic [DW-1:0] r_instr;
  logic [DW-1:0] w_instr_n;
  logic [DW-1:0] r_din;
  logic [DW-1:0] w_din_n;
  logic [DW-1:0] r_imm;
  logic [DW-1:0] w_imm_n;
  logic [AW-1:0] r_rs1;
  logic [AW-1:0] w_rs1_n;
  logic [AW-1:0] r_rs2;
  logic [AW-1:0] w_rs2_n;
  logic [AW-1:0] r_rd;
  logic [AW-1:0] w_rd_n;
  logic [2:0]    r_ctrl;
  logic [2:0]    w_ctrl_n;
  logic          r_req;
  logic          w_req_n;
  logic          r_en;
  logic          w_en_n;
  logic          r_alusrc;
  logic          w_alusrc_n;
  logic          r_illegal;
  logic          w_illegal_n;

  logic [6:0]    w_opc;
  logic [2:0]    w_f3;
  logic [6:0]    w_f7;
  logic [DW-1:0] w_imm_i;
  logic [DW-1:0] w_imm_b;
  logic          w_addi;
  logic          w_add;
  logic          w_sub;
  logic          w_beq;
  logic          w_bne;
  logic          w_taken;

  assign w_opc = r_instr[6:0];
  assign w_f3  = r_instr[14:12];
  assign w_f7  = r_instr[31:25];

  assign w_imm_i = {{(DW-12){r_instr[31]}},
                    r_instr[31:20]};
  assign w_imm_b = {{(DW-13){r_instr[31]}},
                    r_instr[31], r_instr[7],
                    r_instr[30:25], r_instr[11:8],
                    1'b0};

  assign w_addi = (w_opc == 7'b0010011)
               && (w_f3 == 3'b000);
  assign w_add  = (w_opc == 7'b0110011)
               && (w_f3 == 3'b000)
               && (w_f7 == 7'b0000000);
  assign w_sub  = (w_opc == 7'b0110011)
               && (w_f3 == 3'b000)
               && (w_f7 == 7'b0100000);
  assign w_beq  = (w_opc == 7'b1100011)
               && (w_f3 == 3'b000);
  assign w_bne  = (w_opc == 7'b1100011)
               && (w_f3 == 3'b001);

  assign w_taken = ((r_kind == K_BEQ) && bus.eq)
                || ((r_kind == K_BNE) && !bus.eq);

  always_comb begin
    w_state_n   = r_state;
    w_kind_n    = r_kind;
    w_pc_n      = r_pc;
    w_instr_n   = r_instr;
    w_din_n     = r_din;
    w_imm_n     = r_imm;
    w_rs1_n     = r_rs1;
    w_rs2_n     = r_rs2;
    w_rd_n      = r_rd;
    w_ctrl_n    = r_ctrl;
    w_alusrc_n  = r_alusrc;
    w_illegal_n = r_illegal;
    unique case (r_state)
      S_FETCH: begin
        if (r_req && bus.instr_valid) begin
          w_instr_n = bus.instr;
          w_state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        w_rs1_n    = AW'(r_instr[19:15]);
        w_rs2_n    = AW'(r_instr[24:20]);
        w_rd_n     = AW'(r_instr[11:7]);
        w_imm_n    = '0;
        w_alusrc_n = 1'b0;
        w_ctrl_n   = 3'b000;
        w_kind_n   = K_ALU;
        w_state_n  = S_EXEC;
        unique case (1'b1)
          w_addi: begin
            w_imm_n    = w_imm_i;
            w_alusrc_n = 1'b1;
          end
          w_add: w_ctrl_n = 3'b000;
          w_sub: w_ctrl_n = 3'b001;
          w_beq: begin
            w_imm_n  = w_imm_b;
            w_ctrl_n = 3'b001;
            w_kind_n = K_BEQ;
          end
          w_bne: begin
            w_imm_n  = w_imm_b;
            w_ctrl_n = 3'b001;
            w_kind_n = K_BNE;
          end
          default: begin
            w_illegal_n = 1'b1;
            w_state_n   = S_HALT;
          end
        endcase
      end
      S_EXEC: begin
        w_din_n = bus.ALUout;
        if (r_kind == K_ALU) begin
          w_pc_n    = r_pc + PC_STEP;
          w_state_n = S_WB;
        end else begin
          w_pc_n    = w_taken ? (r_pc + r_imm)
                              : (r_pc + PC_STEP);
          w_state_n = S_FETCH;
        end
      end
      S_WB:    w_state_n = S_FETCH;
      S_HALT:  w_state_n = S_HALT;
      default: w_state_n = S_FETCH;
    endcase
    // req/en are registered so both read 0 while reset is held
    w_req_n = (w_state_n == S_FETCH);
    w_en_n  = (w_state_n == S_WB) && (r_rd != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_kind    <= K_ALU;
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_din     <= '0;
      r_imm     <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_ctrl    <= '0;
      r_req     <= 1'b0;
      r_en      <= 1'b0;
      r_alusrc  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_kind    <= w_kind_n;
      r_pc      <= w_pc_n;
      r_instr   <= w_instr_n;
      r_din     <= w_din_n;
      r_imm     <= w_imm_n;
      r_rs1     <= w_rs1_n;
      r_rs2     <= w_rs2_n;
      r_rd      <= w_rd_n;
      r_ctrl    <= w_ctrl_n;
      r_req     <= w_req_n;
      r_en      <= w_en_n;
      r_alusrc  <= w_alusrc_n;
      r_illegal <= w_illegal_n;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [DW-1:0] r_instret;
  logic          w_retire;

  assign w_retire = (r_state == S_WB)
                 || ((r_state == S_EXEC)
                  && (r_kind != K_ALU));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + DW'(1);
    end
  end

  assign instret = r_instret;
`endif

  assign bus.instr_req  = r_req;
  assign bus.instr_addr = r_pc;
  assign bus.rs1        = r_rs1;
  assign bus.rs2        = r_rs2;
  assign bus.rd         = r_rd;
  assign bus.en         = r_en;
  assign bus.din        = r_din;
  assign bus.ALUSrc     = r_alusrc;
  assign bus.ImmOp      = r_imm;
  assign bus.ALU_ctrl   = r_ctrl;
  assign illegal        = r_illegal;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed + randomized bench for alu_control_sequencer against an
// ISA-level model (PC, retire count, expected decoded fields).
module tb_alu_control_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic illegal;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] instret;
`endif

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] m_pc = 32'h0;
  int m_ret = 0;

  alu_control_sequencer_if #(.AW(5), .DW(32)) bus ();

  alu_control_sequencer #(
    .Address_Width(5),
    .Data_Width(32),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .illegal(illegal)
`ifdef SEQ_PERF_CNT_EN
    ,
    .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    bit          legal;
    bit          br;
    bit          bne;
    bit          alusrc;
    int          rd;
    int          rs1;
    int          rs2;
    int          imm;
    int          ctrl;
  } ins_t;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ret(input string tag);
`ifdef SEQ_PERF_CNT_EN
    chk(tag, instret, 32'(m_ret));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // k: 0 ADDI, 1 ADD, 2 SUB, 3 BEQ, 4 BNE
  function automatic ins_t mk(input int k, input int rd, input int rs1,
                              input int rs2, input int imm);
    ins_t t;
    logic [11:0] i12;
    logic [12:0] b13;
    i12 = imm[11:0];
    b13 = imm[12:0];
    t.legal = 1; t.br = 0; t.bne = 0; t.alusrc = 0;
    t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.imm = 0; t.ctrl = 0;
    t.word = 32'h0;
    case (k)
      0: begin
        t.word = {i12, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
        t.alusrc = 1; t.imm = imm; t.rs2 = imm & 31;
      end
      1: t.word = {7'b0000000, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
      2: begin
        t.word = {7'b0100000, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
        t.ctrl = 1;
      end
      default: begin
        t.word = {b13[12], b13[10:5], 5'(rs2), 5'(rs1),
                  (k == 4) ? 3'b001 : 3'b000,
                  b13[4:1], b13[11], 7'b1100011};
        t.br = 1; t.bne = (k == 4); t.ctrl = 1; t.imm = imm;
        t.rd = (((imm >> 1) & 15) << 1) | ((imm >> 11) & 1);
      end
    endcase
    return t;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    m_pc = 32'h0;
    m_ret = 0;
    chk("rst_addr", bus.instr_addr, 32'h0);
    chk("rst_en", 32'(bus.en), 32'h0);
    chk("rst_illegal", 32'(illegal), 32'h0);
    chk("rst_req", 32'(bus.instr_req), 32'h0);
    chk_ret("rst_instret");
    rst_n = 1'b1;
    #1;
    chk("rel_req_low", 32'(bus.instr_req), 32'h0);
    @(negedge clk);
    chk("rel_req_high", 32'(bus.instr_req), 32'h1);
    chk("rel_addr", bus.instr_addr, 32'h0);
  endtask

  task automatic run(input ins_t t, input int waits,
                     input logic [31:0] alu, input logic e,
                     input bit abort_wb);
    bit taken;
    chk("f_req", 32'(bus.instr_req), 32'h1);
    chk("f_addr", bus.instr_addr, m_pc);
    bus.instr_valid = 1'b0;
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      chk("wait_req", 32'(bus.instr_req), 32'h1);
      chk("wait_addr", bus.instr_addr, m_pc);
    end
    bus.instr_valid = 1'b1;
    bus.instr = t.word;
    @(negedge clk);
    // valid stays high with junk while not fetching
    bus.instr = $urandom();
    bus.ALUout = alu;
    bus.eq = e;
    chk("d_req", 32'(bus.instr_req), 32'h0);
    chk("d_en", 32'(bus.en), 32'h0);
    @(negedge clk);
    if (!t.legal) begin
      for (int h = 0; h < 4; h++) begin
        chk("h_illegal", 32'(illegal), 32'h1);
        chk("h_req", 32'(bus.instr_req), 32'h0);
        chk("h_en", 32'(bus.en), 32'h0);
        @(negedge clk);
      end
      bus.instr_valid = 1'b0;
      return;
    end
    bus.instr_valid = 1'b0;
    chk("x_rs1", 32'(bus.rs1), 32'(t.rs1));
    chk("x_rs2", 32'(bus.rs2), 32'(t.rs2));
    chk("x_rd", 32'(bus.rd), 32'(t.rd));
    chk("x_alusrc", 32'(bus.ALUSrc), 32'(t.alusrc));
    chk("x_imm", bus.ImmOp, 32'(t.imm));
    chk("x_ctrl", 32'(bus.ALU_ctrl), 32'(t.ctrl));
    chk("x_en", 32'(bus.en), 32'h0);
    chk("x_req", 32'(bus.instr_req), 32'h0);
    if (t.br) begin
      taken = t.bne ? !e : e;
      m_pc = taken ? m_pc + 32'(t.imm) : m_pc + 32'd4;
      m_ret++;
      @(negedge clk);
      chk("b_req", 32'(bus.instr_req), 32'h1);
      chk("b_addr", bus.instr_addr, m_pc);
      chk("b_en", 32'(bus.en), 32'h0);
      chk_ret("b_instret");
    end else begin
      m_pc = m_pc + 32'd4;
      @(negedge clk);
      chk("wb_en", 32'(bus.en), 32'(t.rd != 0));
      chk("wb_din", bus.din, alu);
      chk("wb_rd", 32'(bus.rd), 32'(t.rd));
      chk("wb_req", 32'(bus.instr_req), 32'h0);
      if (abort_wb) begin
        #1 rst_n = 1'b0;
        #1;
        m_pc = 32'h0;
        m_ret = 0;
        chk("abort_en", 32'(bus.en), 32'h0);
        chk("abort_addr", bus.instr_addr, 32'h0);
        chk("abort_rd", 32'(bus.rd), 32'h0);
        chk_ret("abort_instret");
        do_reset();
        return;
      end
      m_ret++;
      @(negedge clk);
      chk("a_en", 32'(bus.en), 32'h0);
      chk("a_req", 32'(bus.instr_req), 32'h1);
      chk("a_addr", bus.instr_addr, m_pc);
      chk_ret("a_instret");
    end
  endtask

  initial begin
    ins_t t;
    int k;
    int imm;
    bus.instr_valid = 1'b0;
    bus.instr = 32'h0;
    bus.ALUout = 32'h0;
    bus.eq = 1'b0;

    do_reset();

    t = mk(0, 1, 0, 0, 5);
    t.word = 32'h00500093;
    run(t, 0, 32'd5, 1'b0, 0);

    t = mk(1, 3, 1, 2, 0);
    t.word = 32'h002081B3;
    run(t, 0, 32'd11, 1'b0, 0);

    t = mk(4, 0, 1, 0, -4);
    t.word = 32'hFE009EE3;
    run(t, 0, 32'd3, 1'b0, 0);

    t = mk(2, 3, 1, 2, 0);
    t.word = 32'h402081B3;
    run(t, 5, 32'hFFFF_FFFD, 1'b0, 0);

    t = mk(4, 0, 1, 0, -4);
    run(t, 0, 32'd0, 1'b1, 0);

    t = mk(3, 0, 2, 2, 16);
    run(t, 1, 32'd0, 1'b1, 0);

    t = mk(0, 0, 4, 0, -1);
    run(t, 0, 32'h1234, 1'b0, 0);

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 4);
      if (k >= 3) imm = 2 * int'($urandom_range(0, 4095)) - 4096;
      else imm = int'($urandom_range(0, 4095)) - 2048;
      t = mk(k, $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), imm);
      run(t, $urandom_range(0, 3), $urandom(),
          1'($urandom_range(0, 1)), 0);
    end

    t = mk(1, 0, 0, 0, 0);
    t.word = 32'h00000000;
    t.legal = 0;
    run(t, 0, 32'd0, 1'b0, 0);

    do_reset();

    t = mk(1, 3, 1, 2, 0);
    t.word = 32'h002091B3;
    t.legal = 0;
    run(t, 2, 32'd0, 1'b0, 0);

    do_reset();

    t = mk(0, 5, 0, 0, 77);
    run(t, 0, 32'd77, 1'b0, 1);

    t = mk(0, 1, 0, 0, 5);
    run(t, 0, 32'd5, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end
endmodule
